// File: rtl/jpeg_dec_pkg.sv
// Shared types and defaults for the JPEG decode block sequencer.
// The ERR state only exists when JPEG_DEC_WDOG_EN is defined.
package jpeg_dec_pkg;

  localparam int unsigned DEF_BLK_W  = 24;
  localparam int unsigned DEF_COEF_N = 64;
  localparam int unsigned COEF_AW    = $clog2(DEF_COEF_N);
`ifdef JPEG_DEC_WDOG_EN
  localparam int unsigned DEF_WDOG_CYCLES = 1024;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEC   = 3'd1,
    S_IDCT  = 3'd2,
    S_WRITE = 3'd3
`ifdef JPEG_DEC_WDOG_EN
    ,
    S_ERR   = 3'd4
`endif
  } seq_state_e;

endpackage

// File: rtl/jpeg_dec_sequencer_if.sv
// Control/handshake bundle between the decode sequencer and its datapath stages.
interface jpeg_dec_sequencer_if
  import jpeg_dec_pkg::*;
#(
  parameter int unsigned BLK_W   = DEF_BLK_W,
  parameter int unsigned CNT_W   = COEF_AW
);
  logic             cfg_en;
  logic [BLK_W-1:0] cfg_nblk;
  logic             start;
  logic             busy;
  logic             done;
  logic             dec_en;
  logic             coef_valid;
  logic             idct_start;
  logic             idct_done;
  logic             wr_en;
  logic             wr_ready;
  logic [CNT_W-1:0] wr_addr;
  logic [BLK_W-1:0] blk_idx;
  logic             err;

  // Drives configuration and stage handshakes (host / datapath side).
  modport master (
    output cfg_en, cfg_nblk, start, coef_valid, idct_done, wr_ready,
    input  busy, done, dec_en, idct_start, wr_en, wr_addr, blk_idx, err
  );

  // Sequencer side.
  modport slave (
    input  cfg_en, cfg_nblk, start, coef_valid, idct_done, wr_ready,
    output busy, done, dec_en, idct_start, wr_en, wr_addr, blk_idx, err
  );
endinterface

// File: rtl/jpeg_beat_cnt.sv
// Wrapping beat counter with synchronous clear and an all-ones terminal flag.
module jpeg_beat_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         term_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + W'(1);
  end

  assign term_c = (cnt == {W{1'b1}});

endmodule

// File: rtl/jpeg_dec_sequencer.sv
// Per-block DEC -> IDCT -> WRITE sequencer for the JPEG decode path.
// Define JPEG_DEC_WDOG_EN to build the no-progress watchdog and ERR state.
module jpeg_dec_sequencer
  import jpeg_dec_pkg::*;
#(
  parameter int unsigned BLK_W  = DEF_BLK_W,
  parameter int unsigned COEF_N = DEF_COEF_N
`ifdef JPEG_DEC_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  jpeg_dec_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(COEF_N);

  seq_state_e       state_q;
  logic [BLK_W-1:0] nblk_q;
  logic [BLK_W-1:0] blk_rem_q;
  logic [BLK_W-1:0] blk_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             dec_en_q;
  logic             idct_start_q;
  logic             wr_en_q;
  logic [CNT_W-1:0] coef_cnt;
  logic [CNT_W-1:0] wr_addr;
  logic             coef_term_c;
  logic             wr_term_c;
  logic             coef_inc_c;
  logic             beat_c;

  // Enables are only high in their own state, so they also gate stray inputs.
  assign coef_inc_c = dec_en_q & bus.coef_valid;
  assign beat_c     = wr_en_q & bus.wr_ready;

  jpeg_beat_cnt #(.W(CNT_W)) u_coef_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (coef_inc_c),
    .clr    (state_q != S_DEC),
    .cnt    (coef_cnt),
    .term_c (coef_term_c)
  );

  jpeg_beat_cnt #(.W(CNT_W)) u_wr_addr (
    .clk    (clk),
    .rst    (rst),
    .inc    (beat_c),
    .clr    (state_q != S_WRITE),
    .cnt    (wr_addr),
    .term_c (wr_term_c)
  );

`ifdef JPEG_DEC_WDOG_EN
  logic [15:0] wdog_q;
  logic        err_q;
  logic        progress_c;

  assign progress_c = coef_inc_c | ((state_q == S_IDCT) & bus.idct_done) | beat_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      nblk_q       <= '0;
      blk_rem_q    <= '0;
      blk_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dec_en_q     <= 1'b0;
      idct_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
`ifdef JPEG_DEC_WDOG_EN
      wdog_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      idct_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_en) begin
            nblk_q <= bus.cfg_nblk;
          end else if (bus.start) begin
            state_q   <= S_DEC;
            blk_idx_q <= '0;
            blk_rem_q <= nblk_q;
            busy_q    <= 1'b1;
            dec_en_q  <= 1'b1;
          end
        end
        S_DEC: begin
          if (coef_inc_c && coef_term_c) begin
            state_q      <= S_IDCT;
            dec_en_q     <= 1'b0;
            idct_start_q <= 1'b1;
          end
        end
        S_IDCT: begin
          // A done seen alongside our own start pulse belongs to nothing we issued.
          if (bus.idct_done && !idct_start_q) begin
            state_q <= S_WRITE;
            wr_en_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (beat_c && wr_term_c) begin
            wr_en_q <= 1'b0;
            if (blk_rem_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_DEC;
              blk_rem_q <= blk_rem_q - BLK_W'(1);
              blk_idx_q <= blk_idx_q + BLK_W'(1);
              dec_en_q  <= 1'b1;
            end
          end
        end
`ifdef JPEG_DEC_WDOG_EN
        S_ERR: begin
          if (bus.cfg_en) begin
            nblk_q  <= bus.cfg_nblk;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase

`ifdef JPEG_DEC_WDOG_EN
      // Every state change is caused by a progress event, so clearing on progress covers it.
      if (state_q == S_DEC || state_q == S_IDCT || state_q == S_WRITE) begin
        if (progress_c) begin
          wdog_q <= '0;
        end else if (wdog_q == 16'(WDOG_CYCLES - 1)) begin
          state_q      <= S_ERR;
          err_q        <= 1'b1;
          dec_en_q     <= 1'b0;
          wr_en_q      <= 1'b0;
          idct_start_q <= 1'b0;
          wdog_q       <= '0;
        end else begin
          wdog_q <= wdog_q + 16'd1;
        end
      end else begin
        wdog_q <= '0;
      end
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dec_en     = dec_en_q;
  assign bus.idct_start = idct_start_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr;
  assign bus.blk_idx    = blk_idx_q;
`ifdef JPEG_DEC_WDOG_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
